// File: rtl/wrsw_rmon_evq.sv
// wrsw_rmon_evq: collects per-line event pulses into saturating pending counts and serialises them as (index, increment) records
module wrsw_rmon_evq #(
  parameter int g_nevents    = 64,
  parameter int g_pend_width = 3,
  parameter int g_idx_width  = 6
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [g_nevents-1:0]    events_i,
  output logic                    ev_valid_o,
  input  logic                    ev_ready_i,
  output logic [g_idx_width-1:0]  ev_idx_o,
  output logic [g_pend_width-1:0] ev_inc_o,
  output logic [g_nevents-1:0]    ovf_o,
  input  logic                    ovf_clr_i
);

  localparam logic [g_pend_width-1:0] PMAX = '1;

  logic [g_pend_width-1:0] pend_q [g_nevents];
  logic [g_pend_width-1:0] pend_d [g_nevents];
  logic [g_pend_width-1:0] base   [g_nevents];
  logic [g_nevents-1:0]    cand, sat, ovf_q, ovf_d;
  logic [g_idx_width-1:0]  rr_q, rr_d, idx_q, idx_d, gnt_idx;
  logic [g_pend_width-1:0] inc_q, inc_d;
  logic                    valid_q, valid_d, gnt_any, load, grant;

  assign ev_valid_o = valid_q;
  assign ev_idx_o   = idx_q;
  assign ev_inc_o   = inc_q;
  assign ovf_o      = ovf_q;
  assign load       = !valid_q || ev_ready_i;
  assign grant      = load && gnt_any;

  // round-robin search from rr+1; scanning farthest-first lets the nearest candidate win
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = 0; i < g_nevents; i++) cand[i] = pend_q[i] != '0;
    for (int k = g_nevents; k >= 1; k--) begin
      if (cand[g_idx_width'((int'(rr_q) + k) % g_nevents)]) begin
        gnt_any = 1'b1;
        gnt_idx = g_idx_width'((int'(rr_q) + k) % g_nevents);
      end
    end
  end

  // pending counters restart from zero when drained, then absorb this cycle's pulse with saturation
  always_comb begin
    for (int i = 0; i < g_nevents; i++) begin
      base[i]   = (grant && gnt_idx == g_idx_width'(i)) ? '0 : pend_q[i];
      sat[i]    = events_i[i] && base[i] == PMAX;
      pend_d[i] = base[i] + g_pend_width'(events_i[i] && !sat[i]);
      ovf_d[i]  = (ovf_q[i] && !ovf_clr_i) || sat[i];
    end
  end

  // output record register: reloads whenever empty or accepted, otherwise holds
  always_comb begin
    valid_d = load ? gnt_any : valid_q;
    idx_d   = grant ? gnt_idx : idx_q;
    inc_d   = grant ? pend_q[gnt_idx] : inc_q;
    rr_d    = grant ? gnt_idx : rr_q;
  end

  // state registers; rr starts at the last line so line 0 is searched first
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < g_nevents; i++) pend_q[i] <= '0;
      ovf_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      inc_q   <= '0;
      rr_q    <= g_idx_width'(g_nevents - 1);
    end else begin
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      inc_q   <= inc_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: tb/tb_wrsw_rmon_evq.sv
// tb_wrsw_rmon_evq: directed and randomized checks of the event queue against a reference model
module tb_wrsw_rmon_evq;
  localparam int N   = 64;
  localparam int MAX = 7;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         ev_ready_i = 1'b0;
  logic         ovf_clr_i = 1'b0;
  logic [N-1:0] events_i = '0;
  logic         ev_valid_o;
  logic [5:0]   ev_idx_o;
  logic [2:0]   ev_inc_o;
  logic [N-1:0] ovf_o;

  wrsw_rmon_evq dut (
    .clk_i(clk_i), .rst_i(rst_i), .events_i(events_i), .ev_valid_o(ev_valid_o),
    .ev_ready_i(ev_ready_i), .ev_idx_o(ev_idx_o), .ev_inc_o(ev_inc_o),
    .ovf_o(ovf_o), .ovf_clr_i(ovf_clr_i)
  );

  always #5 clk_i = ~clk_i;

  int nchk = 0, nerr = 0;
  int m_pend [N];
  bit m_valid;
  int m_idx, m_inc, m_rr;
  bit [N-1:0] m_ovf;
  int pulses [N], accs [N], drops [N];
  int tot;
  int q_idx [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    foreach (m_pend[i]) m_pend[i] = 0;
    m_valid = 0; m_idx = 0; m_inc = 0; m_rr = N - 1; m_ovf = '0;
  endtask

  task automatic clr_stats();
    foreach (pulses[i]) begin pulses[i] = 0; accs[i] = 0; drops[i] = 0; end
    tot = 0;
    q_idx.delete();
  endtask

  // one clock: record accepted output, advance the model from the spec rules, then compare
  task automatic tick();
    int found;
    bit load;
    int nxt [N];
    if (ev_valid_o && ev_ready_i) begin
      accs[ev_idx_o] += int'(ev_inc_o);
      tot += int'(ev_inc_o);
      q_idx.push_back(int'(ev_idx_o));
    end
    load = !m_valid || ev_ready_i;
    found = -1;
    for (int k = 1; k <= N && found < 0; k++)
      if (m_pend[(m_rr + k) % N] != 0) found = (m_rr + k) % N;
    if (ovf_clr_i) m_ovf = '0;
    for (int i = 0; i < N; i++) begin
      nxt[i] = (load && found == i) ? 0 : m_pend[i];
      if (events_i[i]) begin
        pulses[i]++;
        if (nxt[i] == MAX) begin m_ovf[i] = 1'b1; drops[i]++; end
        else nxt[i]++;
      end
    end
    if (load) begin
      m_valid = found >= 0;
      if (found >= 0) begin m_idx = found; m_inc = m_pend[found]; m_rr = found; end
    end
    m_pend = nxt;
    @(posedge clk_i);
    #1;
    chk("valid", 64'(ev_valid_o), 64'(m_valid));
    chk("idx", 64'(ev_idx_o), 64'(m_idx));
    chk("inc", 64'(ev_inc_o), 64'(m_inc));
    chk("ovf", ovf_o, m_ovf);
  endtask

  task automatic step(input logic [N-1:0] ev, input logic rdy);
    events_i = ev;
    ev_ready_i = rdy;
    tick();
    events_i = '0;
  endtask

  task automatic drain(input int cycles);
    for (int c = 0; c < cycles; c++) step('0, 1'b1);
    chk("drained", 64'(ev_valid_o), 64'd0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    chk("rst_valid", 64'(ev_valid_o), 64'd0);
    chk("rst_ovf", ovf_o, 64'd0);
    m_reset();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  function automatic logic [N-1:0] rnd64();
    logic [N-1:0] r = '1;
    for (int i = 0; i < 8; i++) r &= {$urandom, $urandom};
    return r;
  endfunction

  initial begin
    logic [N-1:0] e;
    do_reset();
    clr_stats();
    // single pulse on line 5: record appears two edges later for exactly one cycle
    step(64'd1 << 5, 1'b1);
    chk("t1_not_yet", 64'(ev_valid_o), 64'd0);
    step('0, 1'b1);
    chk("t1_valid", 64'(ev_valid_o), 64'd1);
    chk("t1_idx", 64'(ev_idx_o), 64'd5);
    chk("t1_inc", 64'(ev_inc_o), 64'd1);
    step('0, 1'b1);
    chk("t1_one_cycle", 64'(ev_valid_o), 64'd0);
    chk("t1_ovf", ovf_o, 64'd0);
    // stalled accumulation on line 3
    clr_stats();
    repeat (4) step(64'd1 << 3, 1'b0);
    chk("t2_rec1", {ev_valid_o, ev_idx_o, ev_inc_o}, {1'b1, 6'd3, 3'd1});
    step('0, 1'b0);
    chk("t2_hold", {ev_valid_o, ev_idx_o, ev_inc_o}, {1'b1, 6'd3, 3'd1});
    step('0, 1'b1);
    chk("t2_rec2", {ev_valid_o, ev_idx_o, ev_inc_o}, {1'b1, 6'd3, 3'd3});
    drain(20);
    chk("t2_total", 64'(tot), 64'd4);
    // saturation on line 7: first pulse rides in the output register, pend saturates at 7, ninth pulse dropped
    clr_stats();
    repeat (9) step(64'd1 << 7, 1'b0);
    chk("t3_ovf7", 64'(ovf_o[7]), 64'd1);
    drain(20);
    chk("t3_total", 64'(tot), 64'd8);
    ovf_clr_i = 1'b1;
    step('0, 1'b1);
    ovf_clr_i = 1'b0;
    chk("t3_ovf_clr", 64'(ovf_o[7]), 64'd0);
    // round-robin order from a fresh pointer, then again after granting line 63
    do_reset();
    clr_stats();
    e = (64'd1 << 0) | (64'd1 << 10) | (64'd1 << 63);
    step(e, 1'b1);
    drain(10);
    step(e, 1'b1);
    drain(10);
    chk("t4_count", 64'(q_idx.size()), 64'd6);
    if (q_idx.size() == 6)
      for (int i = 0; i < 6; i++) chk("t4_order", 64'(q_idx[i]), 64'(i % 3 == 0 ? 0 : i % 3 == 1 ? 10 : 63));
    // pulse coincident with the drain of line 2 is preserved
    clr_stats();
    step(64'd1 << 2, 1'b1);
    step(64'd1 << 2, 1'b1);
    drain(10);
    chk("t5_count", 64'(q_idx.size()), 64'd2);
    chk("t5_total", 64'(tot), 64'd2);
    // random traffic, reset mid-run, then conservation on the second segment
    for (int c = 0; c < 5000; c++) step(rnd64(), 1'($urandom));
    do_reset();
    step('0, 1'b1);
    step('0, 1'b1);
    chk("rst_pend_clear", 64'(ev_valid_o), 64'd0);
    clr_stats();
    for (int c = 0; c < 5000; c++) step(rnd64(), 1'($urandom));
    drain(200);
    for (int i = 0; i < N; i++) chk("conserve", 64'(accs[i]), 64'(pulses[i] - drops[i]));
    chk("rand_ovf", ovf_o, 64'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
